// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: two-stage multi-lane FP compare / min / max unit.
// Ports: in_* valid/ready + operands, out_* result/invalid/tag, sticky flag.
module fp_compare_pipe #(
  parameter int LANES = 2,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [66*LANES-1:0]   in_a,
  input  logic [66*LANES-1:0]   in_b,
  input  logic                  in_sp_dp,
  input  logic [2:0]            in_op,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [66*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_invalid,
  output logic [TAG_W-1:0]      out_tag,
  input  logic                  flag_clr,
  output logic                  sticky_invalid
);

  localparam logic [65:0] QNAN_SP = {32'b0, 34'h3_7FC0_0000};
  localparam logic [65:0] QNAN_DP = 66'h3_7FF8_0000_0000_0000;

  logic [LANES-1:0][65:0] w_a, w_b;
  logic [LANES-1:0][1:0]  w_ea, w_eb;
  logic [LANES-1:0]       w_sa, w_sb, w_qa, w_qb;
  logic [LANES-1:0][62:0] w_ma, w_mb, w_ka, w_kb;
  logic [LANES-1:0]       w_lt, w_eq;

  logic                   r_s1_valid;
  logic [LANES-1:0][65:0] r_a, r_b;
  logic [LANES-1:0][1:0]  r_ea, r_eb;
  logic [LANES-1:0]       r_sa, r_sb, r_qa, r_qb;
  logic [LANES-1:0]       r_lt, r_eq;
  logic [2:0]             r_op;
  logic                   r_sp;
  logic [TAG_W-1:0]       r_tag;

  logic                   r_out_valid;
  logic [LANES-1:0][65:0] r_d;
  logic [LANES-1:0]       r_inv;
  logic [TAG_W-1:0]       r_out_tag;
  logic                   r_sticky;

  logic [LANES-1:0][65:0] w_d;
  logic [LANES-1:0]       w_inv;
  logic                   w_s2_free, w_s1_adv, w_in_fire;

  // SP operands are zero-extended here so MIN/MAX can return them as-is.
  for (genvar g = 0; g < LANES; g++) begin : g_dec
    assign w_a[g]  = in_sp_dp ? {32'b0, in_a[66*g +: 34]}
                              : in_a[66*g +: 66];
    assign w_b[g]  = in_sp_dp ? {32'b0, in_b[66*g +: 34]}
                              : in_b[66*g +: 66];
    assign w_ea[g] = in_sp_dp ? w_a[g][33:32] : w_a[g][65:64];
    assign w_eb[g] = in_sp_dp ? w_b[g][33:32] : w_b[g][65:64];
    assign w_sa[g] = in_sp_dp ? w_a[g][31] : w_a[g][63];
    assign w_sb[g] = in_sp_dp ? w_b[g][31] : w_b[g][63];
    assign w_qa[g] = in_sp_dp ? w_a[g][22] : w_a[g][51];
    assign w_qb[g] = in_sp_dp ? w_b[g][22] : w_b[g][51];
    assign w_ma[g] = in_sp_dp ? {32'b0, w_a[g][30:0]} : w_a[g][62:0];
    assign w_mb[g] = in_sp_dp ? {32'b0, w_b[g][30:0]} : w_b[g][62:0];
    assign w_ka[g] = (w_ea[g] == 2'b10) ? '1 :
                     (w_ea[g] == 2'b01) ? w_ma[g] : '0;
    assign w_kb[g] = (w_eb[g] == 2'b10) ? '1 :
                     (w_eb[g] == 2'b01) ? w_mb[g] : '0;
    assign w_lt[g] = w_ka[g] < w_kb[g];
    assign w_eq[g] = w_ka[g] == w_kb[g];
  end

  assign w_s2_free = ~r_out_valid | out_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_free;
  assign in_ready  = ~r_s1_valid | w_s2_free;
  assign w_in_fire = in_valid & in_ready;

  always_comb begin
    w_d   = '0;
    w_inv = '0;
    for (int i = 0; i < LANES; i++) begin
      logic na, nb, an, sn, bz, eqv, ltv, mlt;
      na  = r_ea[i] == 2'b11;
      nb  = r_eb[i] == 2'b11;
      an  = na | nb;
      sn  = (na & ~r_qa[i]) | (nb & ~r_qb[i]);
      bz  = (r_ea[i] == 2'b00) & (r_eb[i] == 2'b00);
      eqv = bz | (r_eq[i] & (r_sa[i] == r_sb[i]));
      // Signed order from the magnitude key; negatives invert it.
      if (eqv)
        ltv = 1'b0;
      else if (r_sa[i] != r_sb[i])
        ltv = r_sa[i];
      else
        ltv = r_sa[i] ? ~r_lt[i] : r_lt[i];
      // MIN/MAX orders -0 below +0.
      mlt = bz ? (r_sa[i] & ~r_sb[i]) : ltv;
      case (r_op)
        3'b000: begin
          w_d[i][0] = ~an & eqv;
          w_inv[i]  = sn;
        end
        3'b001: begin
          w_d[i][0] = ~an & ltv;
          w_inv[i]  = an;
        end
        3'b010: begin
          w_d[i][0] = ~an & (ltv | eqv);
          w_inv[i]  = an;
        end
        3'b011, 3'b100: begin
          w_inv[i] = sn;
          if (na & nb)
            w_d[i] = r_sp ? QNAN_SP : QNAN_DP;
          else if (na)
            w_d[i] = r_b[i];
          else if (nb)
            w_d[i] = r_a[i];
          else if (r_op == 3'b011)
            w_d[i] = mlt ? r_a[i] : r_b[i];
          else
            w_d[i] = mlt ? r_b[i] : r_a[i];
        end
        3'b101: begin
          w_d[i][0] = an;
          w_inv[i]  = sn;
        end
        default: begin
          w_d[i]   = '0;
          w_inv[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_ea       <= '0;
      r_eb       <= '0;
      r_sa       <= '0;
      r_sb       <= '0;
      r_qa       <= '0;
      r_qb       <= '0;
      r_lt       <= '0;
      r_eq       <= '0;
      r_op       <= '0;
      r_sp       <= 1'b0;
      r_tag      <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_a        <= w_a;
        r_b        <= w_b;
        r_ea       <= w_ea;
        r_eb       <= w_eb;
        r_sa       <= w_sa;
        r_sb       <= w_sb;
        r_qa       <= w_qa;
        r_qb       <= w_qb;
        r_lt       <= w_lt;
        r_eq       <= w_eq;
        r_op       <= in_op;
        r_sp       <= in_sp_dp;
        r_tag      <= in_tag;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_d         <= '0;
      r_inv       <= '0;
      r_out_tag   <= '0;
      r_sticky    <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_out_valid <= 1'b1;
        r_d         <= w_d;
        r_inv       <= w_inv;
        r_out_tag   <= r_tag;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid & out_ready & (|r_inv))
        r_sticky <= 1'b1;
      else if (flag_clr)
        r_sticky <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_d;
  assign out_invalid    = r_inv;
  assign out_tag        = r_out_tag;
  assign sticky_invalid = r_sticky;

endmodule

// File: doc/fp_compare_pipe.md
# fp_compare_pipe

Pipelined, multi-lane floating-point compare / min-max unit for the SM FPU, the sequential companion to the SP/DP adder. Each lane takes two operands in the FPU's internal 66-bit format (2 exception bits + IEEE word; exception 00 zero, 01 normal, 10 infinity, 11 NaN) and produces a compare bit or a min/max operand plus an IEEE invalid flag. It is fully pipelined with a valid/ready handshake, keeps a sticky invalid flag, and sustains one vector per cycle.

## Interface
- LANES, 2, number of independent compare lanes (1..8)
- TAG_W, 4, width of the pass-through tag
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  unit can accept the input vector this cycle
- in_a  in  66*LANES  operand A per lane; lane i is bits [66*i+65:66*i]
- in_b  in  66*LANES  operand B per lane
- in_sp_dp  in  1  1 = SP (bits [33:0] of each lane), 0 = DP (all 66 bits)
- in_op  in  3  000 EQ, 001 LT, 010 LE, 011 MIN, 100 MAX, 101 UNORD, 11x reserved
- in_tag  in  TAG_W  returned unchanged with the result
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts the result
- out_data  out  66*LANES  per-lane result
- out_invalid  out  LANES  per-lane invalid flag
- out_tag  out  TAG_W  tag of this result
- flag_clr  in  1  clears sticky_invalid
- sticky_invalid  out  1  OR of every out_invalid bit ever handed off

## Operation
- **Field selection.**
  - SP: sign [31], exponent [30:23], fraction [22:0], exception [33:32], quiet bit [22].
  - DP: sign [63], exponent [62:52], fraction [51:0], exception [65:64], quiet bit [51].
  - sNaN means exception 11 with quiet bit 0. qNaN means exception 11 with quiet bit 1.
- **Magnitude key.**
  - Zero maps to 0.
  - Infinity maps to all-ones.
  - Normal maps to {exp, frac}.
  - Signed order is derived from this key. +0 and -0 compare equal.
- **Compare ops (EQ, LT, LE, UNORD).**
  - Result is {65'b0, bit}; SP results also have [65:34] = 0.
  - Any NaN operand makes EQ, LT and LE return 0. UNORD returns 1 iff either operand is NaN.
  - Invalid rules:
    - EQ: invalid iff either operand is sNaN.
    - LT, LE (signalling compares): invalid iff either operand is NaN.
    - UNORD: invalid iff either operand is sNaN.
- **MIN / MAX.**
  - Returns the selected operand bit-exact (SP zero-extended to 66 bits).
  - -0 is treated as smaller than +0.
  - Exactly one NaN: return the other operand.
  - Both NaN: return the canonical qNaN. SP: 34'h3_7FC0_0000. DP: 66'h3_7FF8_0000_0000_0000.
  - Invalid iff either operand is sNaN.
- **Reserved ops.** Data 0, invalid 0.
- **Pipeline, stage S1 (registered on input handshake).**
  - Decoded classes, signs, key-less-than and key-equal per lane.
  - Op, mode, tag and the raw operands.
- **Pipeline, stage S2 (registered on S1 advance).** Final data, invalid and tag.
- **Handshake.**
  - s2_free = ~out_valid | out_ready.
  - S1 advances when s1_valid & s2_free.
  - in_ready = ~s1_valid | s2_free. This is combinational from out_ready; no other combinational in→out path exists.
- **Sticky flag.**
  - Sets on any cycle with out_valid & out_ready & |out_invalid.
  - flag_clr clears it. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_data = 0, out_invalid = 0, out_tag = 0, sticky_invalid = 0.
  - Both stage valids cleared.
- Latency:
  - Input handshake in cycle N gives out_valid in cycle N+2 when there is no backpressure.
  - Throughput is 1 vector/cycle while out_ready = 1.
- Backpressure: with out_ready = 0, S2 holds and S1 fills, so in_ready drops in the cycle after S1 becomes occupied. At most 2 vectors are in flight. No vector is dropped or duplicated.
- out_data, out_invalid and out_tag stay stable while out_valid & ~out_ready.
- Simultaneous input and output handshake on a full pipe: both stages shift in the same cycle.
- Reset mid-operation discards all in-flight vectors. The first result after reset belongs to the first post-reset input.
- The in_sp_dp and in_op values that apply to a vector are the ones sampled at its input handshake. Changes between vectors do not affect vectors already in flight.

## Test plan
- SP, LANES=2, op LT. Lane0 A=34'h1_3F80_0000 (1.0), B=34'h1_4000_0000 (2.0). Lane1 operands swapped. Expect out_data lane0 = 1, lane1 = 0, invalid = 00, result at cycle +2.
- SP EQ with A=34'h0_0000_0000 (+0), B=34'h0_8000_0000 (-0). Expect 1. Same operands with MIN: expect 34'h0_8000_0000; with MAX: expect 34'h0_0000_0000.
- SP MAX with A = qNaN 34'h3_7FC0_0000, B = 1.0. Expect 1.0, invalid 0. A = sNaN 34'h3_7FA0_0000 with op LE: expect 0, invalid 1, sticky_invalid = 1 after the output handshake. Pulse flag_clr: expect sticky_invalid back to 0.
- DP MIN with both operands NaN. Expect 66'h3_7FF8_0000_0000_0000. Then DP LT of -inf (66'h2_FFF0_0000_0000_0000) against +1.0 (66'h1_3FF0_0000_0000_0000): expect 1.
- Stream 8 tagged vectors (tags 0..7) with out_ready toggling randomly. Expect tags to emerge in order 0..7 with no loss or duplication, and data held stable while stalled.
- Assert rst_n low for 1 cycle while 2 vectors are in flight. Expect out_valid = 0 immediately and in_ready = 1, and the next result to carry the first post-reset tag.
